// File: rtl/bpu_types.sv
// -----------------------------------------------------------------------------
// bpu_types
// Shared branch-predictor types and constants.
//   FTB_NSET           : number of FTB rows cleared by a full table init
//   UPDATE_QUEUE_DEPTH : default depth of the commit-to-predictor training queue
//   ftq_bpu_meta_t     : one FTQ training slot handed to the predictor
//   upd_state_e        : states of the predictor update controller
// -----------------------------------------------------------------------------
package bpu_types;

    localparam int FTB_NSET           = 16;
    localparam int UPDATE_QUEUE_DEPTH = 4;
    localparam int VADDR_W            = 32;

    typedef struct packed {
        logic               valid;
        logic [VADDR_W-1:0] pc;
        logic [VADDR_W-1:0] target;
        logic [3:0]         cfi_offset;
        logic               taken;
        logic [1:0]         br_type;
    } ftq_bpu_meta_t;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } upd_state_e;

endpackage

// File: rtl/bpu_update_queue.sv
// -----------------------------------------------------------------------------
// bpu_update_queue
// Circular training-entry buffer with two write ports and one read port.
//   clk, rst          : clock, synchronous active-low reset (empties the queue)
//   wr0_en / wr0_data : write port 0 (older entry of the cycle)
//   wr1_en / wr1_data : write port 1 (younger entry of the cycle)
//   rd_en             : pop the head entry
//   rd_data           : current head entry (read from storage, never bypassed)
//   count             : occupancy, 0..DEPTH
// Port 1 lands directly behind port 0, or at the tail itself when port 0 is
// idle, so a lone write on either port never leaves a hole.
// The caller must not write beyond capacity or read when empty.
// -----------------------------------------------------------------------------
module bpu_update_queue
    import bpu_types::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr0_en,
    input  ftq_bpu_meta_t          wr0_data,
    input  logic                   wr1_en,
    input  ftq_bpu_meta_t          wr1_data,
    input  logic                   rd_en,
    output ftq_bpu_meta_t          rd_data,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    ftq_bpu_meta_t    mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [PTR_W-1:0] wr1_addr;
    logic [1:0]       enq_n;

    assign enq_n    = {1'b0, wr0_en} + {1'b0, wr1_en};
    assign wr1_addr = wr0_en ? wr_ptr_reg + PTR_W'(1) : wr_ptr_reg;

    // Power-of-two depth: pointer overflow is the modulo wrap.
    assign wr_ptr_next = wr_ptr_reg + PTR_W'(enq_n);
    assign rd_ptr_next = rd_ptr_reg + PTR_W'(rd_en);
    assign count_next  = count_reg + CNT_W'(enq_n) - CNT_W'(rd_en);

    always_ff @(posedge clk) begin
        if (wr0_en) mem[wr_ptr_reg] <= wr0_data;
        if (wr1_en) mem[wr1_addr]   <= wr1_data;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    assign rd_data = mem[rd_ptr_reg];
    assign count   = count_reg;

endmodule

// File: rtl/bpu_update_ctrl.sv
// -----------------------------------------------------------------------------
// bpu_update_ctrl
// Buffers committed FTQ training slots and feeds them to the predictor one per
// cycle; also sequences a full predictor table initialisation.
//   clk, rst        : clock, synchronous active-low reset
//   commit_meta_i   : two commit slots per cycle, slot 0 older, each with .valid
//   ready_o         : both commit slots can be accepted this cycle
//   update_stall_i  : predictor cannot take an update this cycle
//   update_meta_o   : training entry to the predictor (.valid qualifies it)
//   init_req_i      : pulse requesting a table re-initialisation
//   init_valid_o    : a table row is being cleared this cycle
//   init_index_o    : row being cleared
//   busy_o          : controller is initialising or draining
//   overflow_o      : sticky, a valid slot was dropped because ready_o was low
// Committed training is never discarded by a flush; only reset empties the queue.
// -----------------------------------------------------------------------------
module bpu_update_ctrl
    import bpu_types::*;
#(
    parameter int UPDATE_QUEUE_DEPTH = bpu_types::UPDATE_QUEUE_DEPTH,
    parameter int INIT_ENTRIES       = bpu_types::FTB_NSET
) (
    input  logic                            clk,
    input  logic                            rst,
    input  ftq_bpu_meta_t                   commit_meta_i [2],
    output logic                            ready_o,
    input  logic                            update_stall_i,
    output ftq_bpu_meta_t                   update_meta_o,
    input  logic                            init_req_i,
    output logic                            init_valid_o,
    output logic [$clog2(INIT_ENTRIES)-1:0] init_index_o,
    output logic                            busy_o,
    output logic                            overflow_o
);

    localparam int CNT_W = $clog2(UPDATE_QUEUE_DEPTH) + 1;
    localparam int IDX_W = $clog2(INIT_ENTRIES);

    upd_state_e       state_reg, state_next;
    logic [IDX_W-1:0] row_reg, row_next;
    logic             overflow_reg, overflow_next;

    logic             ready;
    logic             any_valid;
    logic             deq;
    logic             wr0_en, wr1_en;
    ftq_bpu_meta_t    wr0_data, wr1_data;
    ftq_bpu_meta_t    head;
    logic [CNT_W-1:0] q_count;

    // Two free entries are needed so a full pair can always be accepted.
    assign ready     = (state_reg == ST_RUN) && (q_count <= CNT_W'(UPDATE_QUEUE_DEPTH - 2));
    assign any_valid = commit_meta_i[0].valid | commit_meta_i[1].valid;

    // Compact the pair: the oldest valid slot always uses port 0.
    assign wr0_en   = ready & any_valid;
    assign wr0_data = commit_meta_i[0].valid ? commit_meta_i[0] : commit_meta_i[1];
    assign wr1_en   = ready & commit_meta_i[0].valid & commit_meta_i[1].valid;
    assign wr1_data = commit_meta_i[1];

    assign deq = (q_count != '0) & ~update_stall_i & (state_reg != ST_INIT);

    bpu_update_queue #(
        .DEPTH (UPDATE_QUEUE_DEPTH)
    ) u_queue (
        .clk      (clk),
        .rst      (rst),
        .wr0_en   (wr0_en),
        .wr0_data (wr0_data),
        .wr1_en   (wr1_en),
        .wr1_data (wr1_data),
        .rd_en    (deq),
        .rd_data  (head),
        .count    (q_count)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg    <= ST_INIT;
            row_reg      <= '0;
            overflow_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            row_reg      <= row_next;
            overflow_reg <= overflow_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        row_next      = row_reg;
        init_valid_o  = 1'b0;
        overflow_next = overflow_reg | (any_valid & ~ready);
        case (state_reg)
            ST_INIT: begin
                init_valid_o = 1'b1;
                if (row_reg == IDX_W'(INIT_ENTRIES - 1)) begin
                    state_next = ST_RUN;
                    row_next   = '0;
                end else begin
                    row_next = row_reg + IDX_W'(1);
                end
            end
            ST_RUN: begin
                // An entry being written this same cycle makes the queue
                // non-empty, so that request must drain first.
                if (init_req_i) begin
                    if ((q_count == '0) && !wr0_en) begin
                        state_next = ST_INIT;
                        row_next   = '0;
                    end else begin
                        state_next = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (q_count == '0) begin
                    state_next = ST_INIT;
                    row_next   = '0;
                end
            end
            default: begin
                state_next = ST_INIT;
                row_next   = '0;
            end
        endcase
    end

    always_comb begin
        update_meta_o       = head;
        update_meta_o.valid = deq;
    end

    assign ready_o      = ready;
    assign busy_o       = (state_reg != ST_RUN);
    assign init_index_o = row_reg;
    assign overflow_o   = overflow_reg;

endmodule

// File: doc/bpu_update_ctrl.md
BPU_UPDATE_CTRL -- requirements
Module: bpu_update_ctrl

Interface
REQ-001 Parameter UPDATE_QUEUE_DEPTH, default 4, is the number of training entries buffered; it is a power of two and at least 2.
REQ-002 Parameter INIT_ENTRIES, default FTB_NSET, is the number of predictor table rows walked by the init sequence.
REQ-003 clk  input  1  is the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  is the reset; it is synchronous and active-low.
REQ-005 commit_meta_i  input  2 x ftq_bpu_meta_t  carries two FTQ training slots; slot 0 is older, and each slot has its own .valid.
REQ-006 ready_o  output  1  is high when both commit slots can be accepted this cycle.
REQ-007 update_stall_i  input  1  is high while the predictor cannot take an update this cycle.
REQ-008 update_meta_o  output  ftq_bpu_meta_t  is the training entry sent to the predictor; it drives ftq_meta_i of the BPU.
REQ-009 init_req_i  input  1  is a one-cycle pulse requesting a full predictor table re-initialisation.
REQ-010 init_valid_o  output  1  is high when a table row is being cleared this cycle.
REQ-011 init_index_o  output  $clog2(INIT_ENTRIES)  is the table row being cleared.
REQ-012 busy_o  output  1  is high when the block is in any state other than RUN.
REQ-013 overflow_o  output  1  is a sticky flag set when a valid slot arrives while ready_o=0.

Function
REQ-014 The state machine has three states: INIT, RUN and DRAIN.
REQ-015 In INIT, init_valid_o=1 and init_index_o equals the row counter; the counter increments every cycle.
REQ-016 INIT exits to RUN in the cycle after index INIT_ENTRIES-1 is issued, so INIT lasts exactly INIT_ENTRIES cycles.
REQ-017 In INIT, init_req_i is ignored.
REQ-018 In RUN, init_req_i with the queue empty moves to INIT next cycle with the row counter at 0.
REQ-019 In RUN, init_req_i with the queue non-empty moves to DRAIN.
REQ-020 DRAIN moves to INIT in the cycle after the queue becomes empty.
REQ-021 ready_o = (state==RUN) & (count <= UPDATE_QUEUE_DEPTH-2), where count is a $clog2(UPDATE_QUEUE_DEPTH)+1-bit occupancy.
REQ-022 Enqueue happens only when ready_o=1; valid slots are written in age order, invalid slots are skipped without leaving holes, and 0, 1 or 2 entries are written per cycle.
REQ-023 An entry written in cycle T appears at update_meta_o no earlier than T+1; there is no bypass.
REQ-024 update_meta_o is the queue head with .valid = (count!=0) & ~update_stall_i & (state!=INIT); all other fields are don't-care when .valid=0.
REQ-025 A dequeue happens in every cycle where update_meta_o.valid=1.
REQ-026 Enqueue and dequeue in the same cycle give count_next = count + enq_n - deq.
REQ-027 Read and write pointers wrap modulo UPDATE_QUEUE_DEPTH.
REQ-028 In INIT, the queue is empty and no update is issued.
REQ-029 When any valid slot arrives while ready_o=0, the slot is dropped and overflow_o is set to 1 until reset.
REQ-030 Backend flush does not affect this block; committed training is architectural and is never discarded.

Reset
REQ-031 While rst=0 at a clock edge: state is INIT, row counter is 0, queue pointers and count are 0, and overflow_o is 0.
REQ-032 Output values in the first cycle after reset: ready_o=0, busy_o=1, init_valid_o=1, init_index_o=0, update_meta_o.valid=0.
REQ-033 Reset asserted mid-INIT, mid-DRAIN or with a non-empty queue discards all queued entries and restarts INIT from row 0.

Structure
REQ-034 The state enum (INIT/RUN/DRAIN) and UPDATE_QUEUE_DEPTH belong in bpu_types.
REQ-035 The block reuses ftq_bpu_meta_t and FTB_NSET from the existing packages.
REQ-036 The queue storage, pointers and count are one sub-module named bpu_update_queue; it has a 2-write, 1-read port and a count output.

Verification
REQ-037 Release reset -> init_valid_o=1 with init_index_o = 0,1,...,INIT_ENTRIES-1 on consecutive cycles, then ready_o=1 and busy_o=0 on the next cycle.
REQ-038 In RUN with an empty queue, present slot0 A and slot1 B together with update_stall_i=0 -> A is issued at T+1 and B at T+2; count returns to 0.
REQ-039 Present slot0 invalid and slot1 C -> C alone is enqueued and issued at T+1; count peaks at 1.
REQ-040 Hold update_stall_i=1 and present two pairs -> count=4, ready_o=0; a fifth valid slot sets overflow_o=1 and that entry is never issued.
REQ-041 Pulse init_req_i with 3 entries queued and no stall -> DRAIN issues all 3, then INIT runs INIT_ENTRIES cycles, then RUN.
REQ-042 Pull rst low in the middle of INIT and with 2 entries queued -> no further update_meta_o.valid, and init restarts at row 0.
